// File: rtl/alu_branch_dec_pipe.sv
// Pipelined ALU/branch decoder: decodes ALU control and branch class, resolves branch
// direction at push time, and presents results through a DEPTH-entry FIFO.
module alu_branch_dec_pipe #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int SIGNED_CMP = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs_val,
    input  logic [XLEN-1:0]  rt_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alucontrol,
    output logic [2:0]       branchcontrol,
    output logic             branch_taken,
    output logic [CNT_W-1:0] taken_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a beat moves when valid and ready are both high at a rising edge;
    // a presented head holds stable until taken, and flush cancels any same-cycle input beat.
    logic [3:0]    q_alu [DEPTH];
    logic [2:0]    q_br  [DEPTH];
    logic          q_tk  [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    logic [5:0] op, fn;
    logic [3:0] dec_alu;
    logic [2:0] dec_br;
    logic       dec_tk;
    logic       eq, lt, gt;

    assign op = instr[31:26];
    assign fn = instr[5:0];

    assign eq = (rs_val == rt_val);
    assign lt = (SIGNED_CMP != 0) ? ($signed(rs_val) < $signed(rt_val)) : (rs_val < rt_val);
    assign gt = !lt && !eq;

    always_comb begin
        dec_alu = 4'b0010;
        case (op)
            6'b001100: dec_alu = 4'b0000;
            6'b001101: dec_alu = 4'b0001;
            6'b001000: dec_alu = 4'b0010;
            6'b001010: dec_alu = 4'b0111;
            6'b001110: dec_alu = 4'b0011;
            6'b000100,
            6'b000101: dec_alu = 4'b0110;
            6'b000000: begin
                case (fn)
                    6'b100000: dec_alu = 4'b0010;
                    6'b100010: dec_alu = 4'b0110;
                    6'b100100: dec_alu = 4'b0000;
                    6'b100101: dec_alu = 4'b0001;
                    6'b101010: dec_alu = 4'b0111;
                    6'b100110: dec_alu = 4'b0011;
                    6'b100111: dec_alu = 4'b0100;
                    6'b000000: dec_alu = 4'b1000;
                    6'b000010: dec_alu = 4'b1001;
                    default:   dec_alu = 4'b0010;
                endcase
            end
            default: dec_alu = 4'b0010;
        endcase
    end

    always_comb begin
        dec_br = 3'b111;
        dec_tk = 1'b0;
        case (op)
            6'b000001: begin dec_br = 3'b000; dec_tk = !lt;     end
            6'b000011: begin dec_br = 3'b001; dec_tk = lt || eq; end
            6'b000100: begin dec_br = 3'b010; dec_tk = eq;      end
            6'b000101: begin dec_br = 3'b011; dec_tk = !eq;     end
            6'b000110: begin dec_br = 3'b100; dec_tk = lt;      end
            6'b000111: begin dec_br = 3'b101; dec_tk = gt;      end
            default:   begin dec_br = 3'b111; dec_tk = 1'b0;    end
        endcase
    end

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Empty queue shows the idle defaults rather than a stale slot.
    assign alucontrol    = out_valid ? q_alu[rd_ptr] : 4'b0010;
    assign branchcontrol = out_valid ? q_br[rd_ptr]  : 3'b111;
    assign branch_taken  = out_valid ? q_tk[rd_ptr]  : 1'b0;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            q_alu[wr_ptr] <= dec_alu;
            q_br[wr_ptr]  <= dec_br;
            q_tk[wr_ptr]  <= dec_tk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Counted independently of flush so a pop in the flush cycle still registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_count <= '0;
        end else if (pop && q_tk[rd_ptr] && (taken_count != {CNT_W{1'b1}})) begin
            taken_count <= taken_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_branch_dec_pipe.sv
// Bench for alu_branch_dec_pipe: directed vectors into a signed-compare/2-bit-counter instance
// and an unsigned-compare instance in lockstep, checked by a queue-based scoreboard.
module tb_alu_branch_dec_pipe;
    logic        clk = 0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr, rs_val, rt_val;

    logic        in_ready, out_valid, branch_taken;
    logic [3:0]  alucontrol;
    logic [2:0]  branchcontrol;
    logic [1:0]  taken_count;

    logic        u_in_ready, u_out_valid, u_taken;
    logic [3:0]  u_alu;
    logic [2:0]  u_br;
    logic [15:0] u_count;

    int checks = 0;
    int failures = 0;

    // Expected entry: [8:5] alu, [4:2] branch class, [1] taken signed, [0] taken unsigned
    logic [8:0] exp_q[$];
    int         m_cnt_s = 0;
    int         m_cnt_u = 0;

    always #5 clk = ~clk;

    alu_branch_dec_pipe #(.XLEN(32), .DEPTH(2), .SIGNED_CMP(1), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .out_valid(out_valid),
        .out_ready(out_ready), .alucontrol(alucontrol), .branchcontrol(branchcontrol),
        .branch_taken(branch_taken), .taken_count(taken_count)
    );

    alu_branch_dec_pipe #(.XLEN(32), .DEPTH(2), .SIGNED_CMP(0), .CNT_W(16)) dut_u (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .out_valid(u_out_valid),
        .out_ready(out_ready), .alucontrol(u_alu), .branchcontrol(u_br),
        .branch_taken(u_taken), .taken_count(u_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compares every popped head against the scoreboard and tracks counters.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            exp_q.delete();
            m_cnt_s = 0;
            m_cnt_u = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got alu=%0h br=%0h with nothing expected at %0t",
                             alucontrol, branchcontrol, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("alu", 32'(alucontrol), 32'(e[8:5]));
                    chk("br", 32'(branchcontrol), 32'(e[4:2]));
                    chk("taken_s", 32'(branch_taken), 32'(e[1]));
                    chk("u_valid", 32'(u_out_valid), 32'd1);
                    chk("u_alu", 32'(u_alu), 32'(e[8:5]));
                    chk("taken_u", 32'(u_taken), 32'(e[0]));
                    chk("cnt_s", 32'(taken_count), 32'(m_cnt_s));
                    chk("cnt_u", 32'(u_count), 32'(m_cnt_u));
                    if (e[1] && m_cnt_s != 3) m_cnt_s++;
                    if (e[0] && m_cnt_u != 65535) m_cnt_u++;
                end
            end
            if (flush) exp_q.delete();
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [8:0] e);
        int  waited;
        bit  done;
        waited = 0;
        done   = 0;
        in_valid = 1;
        instr    = ins;
        rs_val   = a;
        rt_val   = b;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for instr %0h", ins);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 0;
        out_ready = 1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d entries never appeared, expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 1;
        instr = 0; rs_val = 0; rt_val = 0;
        @(posedge clk);
        #1;
        do_reset();

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu", 32'(alucontrol), 32'b0010);
        chk("rst_br", 32'(branchcontrol), 32'b111);
        chk("rst_taken", 32'(branch_taken), 32'd0);
        chk("rst_count", 32'(taken_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: single add into empty queue is visible on the next cycle.
        out_ready = 0;
        send(32'h014B4820, 32'd0, 32'd0, {4'b0010, 3'b111, 1'b0, 1'b0});
        in_valid = 0;
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_alu", 32'(alucontrol), 32'b0010);
        out_ready = 1;
        @(posedge clk);
        #1;

        // Back-to-back decode vectors streaming at one per cycle.
        send(32'h00000026, 0, 0, {4'b0011, 3'b111, 1'b0, 1'b0});
        send(32'h20000022, 0, 0, {4'b0010, 3'b111, 1'b0, 1'b0});
        send(32'h00000027, 0, 0, {4'b0100, 3'b111, 1'b0, 1'b0});
        send(32'h00000000, 0, 0, {4'b1000, 3'b111, 1'b0, 1'b0});
        send(32'h00000002, 0, 0, {4'b1001, 3'b111, 1'b0, 1'b0});
        send(32'h00000022, 0, 0, {4'b0110, 3'b111, 1'b0, 1'b0});
        send(32'h0000002A, 0, 0, {4'b0111, 3'b111, 1'b0, 1'b0});
        send(32'h00000024, 0, 0, {4'b0000, 3'b111, 1'b0, 1'b0});
        send(32'h00000025, 0, 0, {4'b0001, 3'b111, 1'b0, 1'b0});
        send(32'h0000003F, 0, 0, {4'b0010, 3'b111, 1'b0, 1'b0});
        send(32'h30000000, 0, 0, {4'b0000, 3'b111, 1'b0, 1'b0});
        send(32'h34000000, 0, 0, {4'b0001, 3'b111, 1'b0, 1'b0});
        send(32'h28000000, 0, 0, {4'b0111, 3'b111, 1'b0, 1'b0});
        send(32'h38000000, 0, 0, {4'b0011, 3'b111, 1'b0, 1'b0});
        send(32'hFC000000, 0, 0, {4'b0010, 3'b111, 1'b0, 1'b0});
        chk("stream_in_ready", 32'(in_ready), 32'd1);

        // Branch vectors: signed vs unsigned resolution.
        send(32'h10000000, 32'd5, 32'd5, {4'b0110, 3'b010, 1'b1, 1'b1});
        send(32'h14000000, 32'd5, 32'd5, {4'b0110, 3'b011, 1'b0, 1'b0});
        send(32'h18000000, 32'hFFFFFFFF, 32'd1, {4'b0010, 3'b100, 1'b1, 1'b0});
        send(32'h1C000000, 32'hFFFFFFFF, 32'd1, {4'b0010, 3'b101, 1'b0, 1'b1});
        send(32'h04000000, 32'd3, 32'd3, {4'b0010, 3'b000, 1'b1, 1'b1});
        send(32'h0C000000, 32'hFFFFFFFE, 32'd7, {4'b0010, 3'b001, 1'b1, 1'b0});
        send(32'h14000000, 32'd1, 32'd2, {4'b0110, 3'b011, 1'b1, 1'b1});
        drain();

        // Backpressure: fill the queue, confirm stall and a stable head, then release.
        out_ready = 0;
        send(32'h00000027, 0, 0, {4'b0100, 3'b111, 1'b0, 1'b0});
        send(32'h00000000, 0, 0, {4'b1000, 3'b111, 1'b0, 1'b0});
        in_valid = 1;
        instr = 32'h00000002;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head", 32'(alucontrol), 32'b0100);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_head", 32'(alucontrol), 32'b0100);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 0;
        out_ready = 1;
        send(32'h00000024, 0, 0, {4'b0000, 3'b111, 1'b0, 1'b0});
        send(32'h00000025, 0, 0, {4'b0001, 3'b111, 1'b0, 1'b0});
        send(32'h00000026, 0, 0, {4'b0011, 3'b111, 1'b0, 1'b0});
        send(32'h0000002A, 0, 0, {4'b0111, 3'b111, 1'b0, 1'b0});
        send(32'h00000022, 0, 0, {4'b0110, 3'b111, 1'b0, 1'b0});
        in_valid = 0;
        @(negedge clk);
        chk("wrap_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Flush with a full queue and a same-cycle input beat.
        out_ready = 0;
        send(32'h30000000, 0, 0, {4'b0000, 3'b111, 1'b0, 1'b0});
        send(32'h34000000, 0, 0, {4'b0001, 3'b111, 1'b0, 1'b0});
        in_valid = 1;
        instr = 32'h00000027;
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        in_valid = 0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1;
        idle(5);
        send(32'h38000000, 0, 0, {4'b0011, 3'b111, 1'b0, 1'b0});
        drain();

        // Saturating counter: five taken branches into a 2-bit counter.
        do_reset();
        @(negedge clk);
        chk("cnt_after_reset", 32'(taken_count), 32'd0);
        @(posedge clk);
        #1;
        repeat (5) send(32'h10000000, 32'd9, 32'd9, {4'b0110, 3'b010, 1'b1, 1'b1});
        drain();
        idle(2);
        @(negedge clk);
        chk("cnt_sat", 32'(taken_count), 32'd3);
        chk("cnt_u_five", 32'(u_count), 32'd5);
        @(posedge clk);
        #1;
        idle(3);
        @(negedge clk);
        chk("cnt_sat_hold", 32'(taken_count), 32'd3);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("cnt_final_reset", 32'(taken_count), 32'd0);
        chk("cnt_u_final_reset", 32'(u_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
